// File: rtl/col_parity_ctrl.sv
// Column-parity sequencer: reads each 25-bit slice, shifts it out bit-serially
// and writes the five accumulated column parities per slice.
module col_parity_ctrl #(
    parameter int SLICES     = 64,
    parameter int SLICE_BITS = 25,
    parameter int COLS       = 5,
    parameter int AW         = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_rd,
    output logic [AW-1:0]         mem_rd_addr,
    input  logic [SLICE_BITS-1:0] mem_rd_data,
    output logic                  par_wr,
    output logic [AW-1:0]         par_wr_addr,
    output logic [COLS-1:0]       par_wr_data,
    output logic                  en,
    output logic                  pout,
    output logic                  co_c25,
    output logic                  co_c64
);

    localparam int CW = $clog2(SLICE_BITS);
    localparam int XW = $clog2(COLS);
    localparam logic [CW-1:0] LAST_BIT = CW'(SLICE_BITS - 1);
    localparam logic [XW-1:0] LAST_COL = XW'(COLS - 1);
    localparam logic [AW-1:0] LAST_Z   = AW'(SLICES - 1);

    typedef enum logic [2:0] {IDLE, RD, LOAD, SHIFT, WR, DONE} state_t;

    state_t                  state;
    logic [AW-1:0]           c64;
    logic [CW-1:0]           c25;
    logic [XW-1:0]           col;
    logic [SLICE_BITS-1:0]   sreg;
    logic [COLS-1:0]         parity;

    function automatic logic [COLS-1:0] acc_parity(input logic [COLS-1:0] p,
                                                   input logic [XW-1:0]   x,
                                                   input logic            b);
        logic [COLS-1:0] r;
        r = p;
        for (int k = 0; k < COLS; k++) begin
            if (x == XW'(k)) r[k] = r[k] ^ b;
        end
        return r;
    endfunction

    // Outputs are registered together with the state they belong to, so each
    // strobe is high exactly during the matching state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            c64         <= '0;
            c25         <= '0;
            col         <= '0;
            sreg        <= '0;
            parity      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            mem_rd      <= 1'b0;
            mem_rd_addr <= '0;
            par_wr      <= 1'b0;
            par_wr_addr <= '0;
            par_wr_data <= '0;
            en          <= 1'b0;
            pout        <= 1'b0;
            co_c25      <= 1'b0;
            co_c64      <= 1'b0;
        end else if (abort && state != IDLE) begin
            state  <= IDLE;
            c64    <= '0;
            c25    <= '0;
            col    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            mem_rd <= 1'b0;
            par_wr <= 1'b0;
            en     <= 1'b0;
            pout   <= 1'b0;
            co_c25 <= 1'b0;
            co_c64 <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= RD;
                        c64         <= '0;
                        busy        <= 1'b1;
                        mem_rd      <= 1'b1;
                        mem_rd_addr <= '0;
                        co_c64      <= (LAST_Z == '0);
                    end
                end
                RD: begin
                    state  <= LOAD;
                    mem_rd <= 1'b0;
                end
                LOAD: begin
                    state  <= SHIFT;
                    sreg   <= mem_rd_data;
                    parity <= '0;
                    c25    <= '0;
                    col    <= '0;
                    en     <= 1'b1;
                    pout   <= mem_rd_data[0];
                    co_c25 <= (LAST_BIT == '0);
                end
                SHIFT: begin
                    sreg   <= sreg >> 1;
                    parity <= acc_parity(parity, col, sreg[0]);
                    c25    <= c25 + 1'b1;
                    col    <= (col == LAST_COL) ? '0 : col + 1'b1;
                    if (c25 == LAST_BIT) begin
                        state       <= WR;
                        en          <= 1'b0;
                        pout        <= 1'b0;
                        co_c25      <= 1'b0;
                        par_wr      <= 1'b1;
                        par_wr_addr <= c64;
                        par_wr_data <= acc_parity(parity, col, sreg[0]);
                    end else begin
                        pout   <= sreg[1];
                        co_c25 <= (c25 + 1'b1 == LAST_BIT);
                    end
                end
                WR: begin
                    par_wr <= 1'b0;
                    if (c64 == LAST_Z) begin
                        state  <= DONE;
                        done   <= 1'b1;
                        co_c64 <= 1'b0;
                    end else begin
                        state       <= RD;
                        c64         <= c64 + 1'b1;
                        mem_rd      <= 1'b1;
                        mem_rd_addr <= c64 + 1'b1;
                        co_c64      <= (c64 + 1'b1 == LAST_Z);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    c64   <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_col_parity_ctrl.sv
// Bench for col_parity_ctrl: table-driven memory patterns, random slices
// against a column-parity model, and abort/reset disturbance sequences.
module tb_col_parity_ctrl;

    localparam int SLICES = 64;
    localparam int SB     = 25;
    localparam int COLS   = 5;
    localparam int AW     = 6;

    logic            clk = 1'b0;
    logic            rst, start, abort;
    logic            busy, done, mem_rd, par_wr, en, pout, co_c25, co_c64;
    logic [AW-1:0]   mem_rd_addr, par_wr_addr;
    logic [SB-1:0]   mem_rd_data = '0;
    logic [COLS-1:0] par_wr_data;

    logic [SB-1:0]   mem     [SLICES];
    logic [COLS-1:0] exp_par [SLICES];

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [AW-1:0]   wr_addr_q [$];
    logic [COLS-1:0] wr_data_q [$];
    logic            pout_q    [$];
    int en_cnt, c25_cnt, c25_bad, c2564_cnt, c64_cnt, c64_bad, busy_cnt, done_cnt, done_edge, cur_z;

    typedef struct {
        logic [SB-1:0]   w_even;
        logic [SB-1:0]   w_odd;
        logic [COLS-1:0] p_even;
        logic [COLS-1:0] p_odd;
        int              ones;
    } vec_t;
    vec_t vecs [6];

    col_parity_ctrl #(.SLICES(SLICES), .SLICE_BITS(SB), .COLS(COLS), .AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .busy(busy), .done(done), .mem_rd(mem_rd), .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data), .par_wr(par_wr), .par_wr_addr(par_wr_addr),
        .par_wr_data(par_wr_data), .en(en), .pout(pout), .co_c25(co_c25), .co_c64(co_c64)
    );

    always #5 clk = ~clk;

    // Slice memory with one cycle of read latency; edge counter.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_rd) mem_rd_data <= mem[mem_rd_addr];
    end

    always @(negedge clk) begin
        if (mem_rd) cur_z = int'(mem_rd_addr);
        if (par_wr) begin
            wr_addr_q.push_back(par_wr_addr);
            wr_data_q.push_back(par_wr_data);
        end
        if (en) begin
            en_cnt++;
            pout_q.push_back(pout);
        end
        if (co_c25) begin
            c25_cnt++;
            if (!en) c25_bad++;
        end
        if (co_c25 && co_c64) c2564_cnt++;
        if (co_c64) begin
            c64_cnt++;
            if (cur_z != SLICES - 1) c64_bad++;
        end
        if (busy) busy_cnt++;
        if (done) begin
            done_cnt++;
            done_edge = cyc;
        end
    end

    function automatic logic [COLS-1:0] ref_par(input logic [SB-1:0] w);
        logic [COLS-1:0] p;
        p = '0;
        for (int i = 0; i < SB; i++) if (w[i]) p[i % COLS] = ~p[i % COLS];
        return p;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic clear_mon();
        wr_addr_q.delete();
        wr_data_q.delete();
        pout_q.delete();
        en_cnt = 0; c25_cnt = 0; c25_bad = 0; c2564_cnt = 0; c64_cnt = 0;
        c64_bad = 0; busy_cnt = 0; done_cnt = 0; done_edge = 0; cur_z = 0;
    endtask

    task automatic start_pass(output int k);
        clear_mon();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 k = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_pass(input bit mid_start, input int ones_exp);
        int k, n, bad, ones, idx;
        start_pass(k);
        if (mid_start) begin
            repeat (400) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        n = 0;
        while (done_cnt == 0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", 64'(done_cnt != 0), 64'd1);
        repeat (3) @(negedge clk);
        chk("done_latency", 64'(done_edge - k), 64'd1792);
        chk("done_count", 64'(done_cnt), 64'd1);
        chk("busy_cycles", 64'(busy_cnt), 64'd1793);
        chk("busy_after", 64'(busy), 64'd0);
        chk("en_count", 64'(en_cnt), 64'd1600);
        chk("c25_count", 64'(c25_cnt), 64'd64);
        chk("c25_without_en", 64'(c25_bad), 64'd0);
        chk("c25_and_c64", 64'(c2564_cnt), 64'd1);
        chk("c64_cycles", 64'(c64_cnt), 64'd28);
        chk("c64_wrong_slice", 64'(c64_bad), 64'd0);
        chk("wr_count", 64'(wr_addr_q.size()), 64'(SLICES));
        for (int z = 0; z < SLICES && z < wr_addr_q.size(); z++) begin
            chk($sformatf("wr_addr_%0d", z), 64'(wr_addr_q[z]), 64'(z));
            chk($sformatf("par_z%0d", z), 64'(wr_data_q[z]), 64'(exp_par[z]));
        end
        bad = 0; ones = 0; idx = 0;
        for (int z = 0; z < SLICES; z++) begin
            for (int i = 0; i < SB; i++) begin
                if (idx < pout_q.size()) begin
                    if (pout_q[idx] !== mem[z][i]) bad++;
                    if (pout_q[idx] === 1'b1) ones++;
                end
                idx++;
            end
        end
        chk("pout_stream_errors", 64'(bad), 64'd0);
        if (ones_exp >= 0) chk("pout_ones", 64'(ones), 64'(ones_exp));
    endtask

    task automatic fill_random();
        for (int z = 0; z < SLICES; z++) begin
            mem[z] = SB'($urandom);
            exp_par[z] = ref_par(mem[z]);
        end
    endtask

    task automatic wait_writes(input int cnt);
        int n;
        n = 0;
        while (wr_addr_q.size() < cnt && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("reach_slice", 64'(wr_addr_q.size() >= cnt), 64'd1);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int k;
        logic [5:0] zz;
        vecs[0] = '{25'h0000000, 25'h0000000, 5'b00000, 5'b00000, 0};
        vecs[1] = '{25'h1FFFFFF, 25'h1FFFFFF, 5'b11111, 5'b11111, 1600};
        vecs[2] = '{25'h0000080, 25'h0000000, 5'b00100, 5'b00000, 32};
        vecs[3] = '{25'h1084210, 25'h1084210, 5'b10000, 5'b10000, 320};
        vecs[4] = '{25'h0000003, 25'h1FFFFFF, 5'b00011, 5'b11111, 864};
        vecs[5] = '{25'h0000021, 25'h1000000, 5'b00000, 5'b10000, 96};

        rst = 1'b0; start = 1'b0; abort = 1'b0;
        for (int z = 0; z < SLICES; z++) mem[z] = '0;
        #12;
        chk("reset_outputs", 64'({busy, done, mem_rd, par_wr, en, pout, co_c25, co_c64,
                                  mem_rd_addr, par_wr_addr, par_wr_data}), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_busy", 64'(busy), 64'd0);

        for (int v = 0; v < 6; v++) begin
            for (int z = 0; z < SLICES; z++) begin
                mem[z]     = (z % 2 == 0) ? vecs[v].w_even : vecs[v].w_odd;
                exp_par[z] = (z % 2 == 0) ? vecs[v].p_even : vecs[v].p_odd;
            end
            run_pass(1'b0, vecs[v].ones);
        end

        // Row y=0 ones mixed with the slice index; start pulsed mid-pass.
        for (int z = 0; z < SLICES; z++) begin
            zz = 6'(z);
            mem[z]     = 25'h1F ^ (SB'(z) << 5);
            exp_par[z] = 5'b11111 ^ zz[4:0] ^ {4'b0000, zz[5]};
        end
        run_pass(1'b1, -1);

        repeat (2) begin
            fill_random();
            run_pass(1'b0, -1);
        end

        // Abort during slice 10 shift.
        fill_random();
        start_pass(k);
        wait_writes(10);
        abort = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_strobes", 64'({en, par_wr, done, mem_rd, co_c25}), 64'd0);
        @(negedge clk);
        abort = 1'b0;
        repeat (100) @(negedge clk);
        chk("abort_writes", 64'(wr_addr_q.size()), 64'd10);
        chk("abort_no_done", 64'(done_cnt), 64'd0);
        chk("abort_idle", 64'(busy), 64'd0);
        fill_random();
        run_pass(1'b0, -1);

        // Asynchronous reset during slice 40.
        fill_random();
        start_pass(k);
        wait_writes(40);
        #2 rst = 1'b0;
        #1;
        chk("rst_mid_outputs", 64'({busy, done, mem_rd, par_wr, en, pout, co_c25, co_c64,
                                    mem_rd_addr, par_wr_addr, par_wr_data}), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (50) @(negedge clk);
        chk("rst_no_restart", 64'(busy), 64'd0);
        chk("rst_writes", 64'(wr_addr_q.size()), 64'd40);
        chk("rst_no_done", 64'(done_cnt), 64'd0);
        fill_random();
        run_pass(1'b0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
